// File: rtl/gamma_pkg.sv
// Shared constants and state type for the gamma LUT loader and the LUT itself.
package gamma_pkg;
  localparam int GAMMA_ENTRIES = 768;
  localparam int GAMMA_ADDR_W  = 10;
  localparam int GAMMA_CH_SIZE = 256;

  typedef enum logic [1:0] {IDLE, FILL, LOAD} gamma_ld_state_t;
endpackage

// File: rtl/gamma_loader.sv
// Owns the gamma LUT write port: identity fill after reset or on request, host curve
// streaming over a valid/ready byte port, and gating of the video-side gamma enable.
module gamma_loader
  import gamma_pkg::*;
#(
  parameter int ENTRIES = GAMMA_ENTRIES,
  parameter int ADDR_W  = GAMMA_ADDR_W
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              start_default,
  input  logic              load_start,
  input  logic              load_abort,
  input  logic              s_valid,
  input  logic [7:0]        s_data,
  output logic              s_ready,
  input  logic              enable_req,
  output logic              gamma_wr,
  output logic [ADDR_W-1:0] gamma_wr_addr,
  output logic [7:0]        gamma_value,
  output logic              gamma_en,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(ENTRIES - 1);

  gamma_ld_state_t   state_q;
  logic [ADDR_W-1:0] cnt_q;
  logic              curve_valid_q;
  logic              wr_q, done_q, err_q, en_q, busy_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        val_q;

  assign s_ready       = (state_q == LOAD);
  assign gamma_wr      = wr_q;
  assign gamma_wr_addr = addr_q;
  assign gamma_value   = val_q;
  assign gamma_en      = en_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign error         = err_q;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= FILL;
      cnt_q         <= '0;
      curve_valid_q <= 1'b0;
      wr_q          <= 1'b0;
      addr_q        <= '0;
      val_q         <= '0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      en_q          <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      wr_q   <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      // Registered from current state so busy falls the cycle after done.
      busy_q <= (state_q != IDLE);
      en_q   <= enable_req & curve_valid_q;
      case (state_q)
        IDLE: begin
          if (load_start) begin
            state_q       <= LOAD;
            cnt_q         <= '0;
            curve_valid_q <= 1'b0;
          end else if (start_default) begin
            state_q       <= FILL;
            cnt_q         <= '0;
            curve_valid_q <= 1'b0;
          end
        end
        FILL: begin
          if (load_start) begin
            state_q <= LOAD;
            cnt_q   <= '0;
          end else begin
            // Low byte of the address wraps per 256-entry channel: identity on R, G and B.
            wr_q   <= 1'b1;
            addr_q <= cnt_q;
            val_q  <= cnt_q[7:0];
            if (cnt_q == LAST) begin
              state_q       <= IDLE;
              cnt_q         <= '0;
              curve_valid_q <= 1'b1;
              done_q        <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        LOAD: begin
          if (load_abort) begin
            err_q   <= 1'b1;
            state_q <= FILL;
            cnt_q   <= '0;
          end else if (load_start) begin
            err_q <= 1'b1;
            cnt_q <= '0;
          end else if (s_valid) begin
            wr_q   <= 1'b1;
            addr_q <= cnt_q;
            val_q  <= s_data;
            if (cnt_q == LAST) begin
              state_q       <= IDLE;
              cnt_q         <= '0;
              curve_valid_q <= 1'b1;
              done_q        <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        default: begin
          state_q <= FILL;
          cnt_q   <= '0;
        end
      endcase
    end
  end

endmodule
